fib_arbiter: RTL

//   Shares a single fibonacci engine (din/start/dout/done) between NREQ requesters.

---
 rtl/fib_arb_pkg.sv | 20 ++
 rtl/rr_picker.sv | 40 ++++
 rtl/fib_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fib_arb_pkg.sv
// Shared types and constants for the fibonacci-engine arbiter.
package fib_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef logic [15:0] fib_word_t;

    // F(24) = 46368 is the largest fibonacci number that fits in 16 bits.
    localparam int FIB_MAX_N_16B = 24;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr (mod NREQ),
// returned as a one-hot grant plus its binary index.
module rr_picker
    import fib_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  id_o,
    output logic            any_o
);

    // One extra bit so ptr + offset can exceed NREQ before the wrap.
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        any_o = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_i} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                id_o       = idx;
            end
        end
    end

endmodule

// File: rtl/fib_arbiter.sv
// Round-robin arbiter sharing one fibonacci engine among NREQ requesters, one job at a time.
// Define FIB_ARB_TIMEOUT_EN to add a BUSY-state watchdog of TIMEOUT_CYC cycles.
module fib_arbiter
    import fib_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int MAX_N       = FIB_MAX_N_16B,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0][15:0] req_n,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output fib_word_t             rsp_data,
    output logic                  rsp_err,
    output fib_word_t             fib_din,
    output logic                  fib_start,
    input  fib_word_t             fib_dout,
    input  logic                  fib_done,
    output logic                  busy,
    output state_t                dbg_state
);

    // Handshake: a request is accepted on a rising edge where req_valid[i] & req_ready[i];
    // req_ready is one-hot and only ever high in IDLE. rsp_valid is a one-cycle strobe.

    localparam int IDW = id_width(NREQ);

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    fib_word_t       n_q, n_d;
    fib_word_t       data_q, data_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_id;
    logic            pick_any;
    fib_word_t       pick_n;
    logic            timeout;

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .id_o  (pick_id),
        .any_o (pick_any)
    );

    assign pick_n = req_n[pick_id];

`ifdef FIB_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d   = (state_q == BUSY) ? cnt_q + 16'd1 : 16'd0;
    assign timeout = (cnt_q == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        n_d       = n_q;
        data_d    = data_q;
        err_d     = err_q;
        req_ready = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        fib_din   = '0;
        fib_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    // Gated by reset_n so a held request cannot show ready while in reset.
                    req_ready = pick_gnt & {NREQ{reset_n}};
                    id_d      = pick_id;
                    n_d       = pick_n;
                    data_d    = '0;
                    ptr_d     = (pick_id == IDW'(NREQ - 1)) ? '0 : pick_id + IDW'(1);
                    if (pick_n > fib_word_t'(MAX_N)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // fib_done is not looked at here, masking a level left over from the last job.
                fib_start = 1'b1;
                fib_din   = n_q;
                state_d   = BUSY;
            end
            BUSY: begin
                fib_din = n_q;
                if (fib_done) begin
                    data_d  = fib_dout;
                    state_d = RESP;
                end else if (timeout) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                fib_din         = n_q;
                rsp_valid[id_q] = 1'b1;
                rsp_data        = data_q;
                rsp_err         = err_q;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            n_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            n_q     <= n_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule
